dac_serial_054539: RTL and testbench

Output serializer downstream of `top_054539`. It captures each parallel stereo sample pair (`AUDIO_OUT_L` / `AUDIO_OUT_R`) into a one-deep holding register. It then shifts the pair out as a 32-bit left-justified serial frame, with bit clock and word clock, to the external 16-bit stereo DAC. It also flags overrun (producer too fast) and underrun (producer too slow).

---
 rtl/dac_054539_pkg.sv | 17 +
 rtl/dac_bclk_gen.sv | 39 +++
 rtl/dac_serial_054539.sv | 122 ++++++++++++
 tb/tb_dac_serial_054539.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_054539_pkg.sv
// Shared definitions for the 054539 stereo DAC serializer.
//   SAMPLE_W   - width of one channel sample
//   FRAME_BITS - bits per stereo frame (left then right)
//   FRAME_LAST - bit counter value of the final bit in a frame
//   stereo_t   - packed {l, r} sample pair, left channel in the upper half
package dac_054539_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int FRAME_LAST = 31;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } stereo_t;

endpackage

// File: rtl/dac_bclk_gen.sv
// Bit clock generator for the DAC serializer.
// A counter runs 0..BCLK_DIV-1; at terminal count it wraps and toggles bclk.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   bclk     out  registered serial bit clock (reset 0)
//   fall_evt out  high in the cycle whose closing edge drives bclk 1->0
module dac_bclk_gen #(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall_evt
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_TC = CW'(BCLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          div_tc;

    assign div_tc   = (div_cnt == DIV_TC);
    // bclk is currently high, so this terminal count toggles it low
    assign fall_evt = div_tc & bclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dac_serial_054539.sv
// Stereo sample serializer for an external 16-bit DAC.
// Captures parallel L/R pairs into a one-deep holding register and shifts
// them out as a 32-bit left-justified frame (left on LRCK=0, right on LRCK=1),
// MSB first, data changing on the BCLK falling edge.
// Ports:
//   CLK, RESET           system clock, async active-high reset
//   SAMPLE_L/R, _VALID   parallel sample pair and one-cycle capture strobe
//   SAMPLE_READY         holding register empty (advisory)
//   OVR_CLR, OVERRUN     sticky overrun flag and its clear
//   UNDERRUN             pulse: frame loaded with holding empty (repeat)
//   FRAME_START          pulse on every frame load
//   DAC_BCLK/LRCK/SDATA  serial DAC interface
module dac_serial_054539
    import dac_054539_pkg::*;
#(
    parameter int BCLK_DIV = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SAMPLE_W-1:0] SAMPLE_L,
    input  logic [SAMPLE_W-1:0] SAMPLE_R,
    input  logic                SAMPLE_VALID,
    output logic                SAMPLE_READY,
    input  logic                OVR_CLR,
    output logic                OVERRUN,
    output logic                UNDERRUN,
    output logic                FRAME_START,
    output logic                DAC_BCLK,
    output logic                DAC_LRCK,
    output logic                DAC_SDATA
);

    localparam logic [4:0] BIT_LAST = 5'(FRAME_LAST);

    logic                  bclk;
    logic                  fall_evt;
    logic                  load;
    logic [4:0]            bit_cnt;
    logic [4:0]            bit_nxt;
    logic                  hold_full;
    stereo_t               hold_q;
    stereo_t               last_q;
    logic [FRAME_BITS-1:0] shift_q;

    dac_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (CLK),
        .rst      (RESET),
        .bclk     (bclk),
        .fall_evt (fall_evt)
    );

    assign bit_nxt      = bit_cnt + 5'd1;
    assign load         = fall_evt && (bit_cnt == BIT_LAST);
    assign DAC_BCLK     = bclk;
    assign DAC_SDATA    = shift_q[FRAME_BITS-1];
    assign SAMPLE_READY = ~hold_full;

    // Bit counter and word clock; reset to the last bit so the first fall
    // event after reset is a frame load.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt  <= BIT_LAST;
            DAC_LRCK <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt  <= bit_nxt;
            DAC_LRCK <= bit_nxt[4];
        end
    end

    // Shift register and repeat buffer. An empty holding register at load
    // time replays the previous pair rather than sending silence.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shift_q <= '0;
            last_q  <= '0;
        end else if (load) begin
            if (hold_full) begin
                shift_q <= hold_q;
                last_q  <= hold_q;
            end else begin
                shift_q <= last_q;
            end
        end else if (fall_evt) begin
            shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    // Holding register. A load reads the pre-edge contents, so a capture in
    // the same cycle still lands and leaves the register full.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (SAMPLE_VALID) begin
            hold_q    <= '{l: SAMPLE_L, r: SAMPLE_R};
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Status flags. Overwriting a pair the load is consuming this same
    // cycle is not an overrun; set beats clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVERRUN     <= 1'b0;
            UNDERRUN    <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= load;
            UNDERRUN    <= load && !hold_full;
            if (SAMPLE_VALID && hold_full && !load) begin
                OVERRUN <= 1'b1;
            end else if (OVR_CLR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_serial_054539.sv
module tb_dac_serial_054539;

    localparam int BD    = 2;
    localparam int FRAME = 64 * BD;

    logic        CLK;
    logic        RESET;
    logic [15:0] SAMPLE_L;
    logic [15:0] SAMPLE_R;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY;
    logic        OVR_CLR;
    logic        OVERRUN;
    logic        UNDERRUN;
    logic        FRAME_START;
    logic        DAC_BCLK;
    logic        DAC_LRCK;
    logic        DAC_SDATA;

    dac_serial_054539 #(.BCLK_DIV(BD)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SAMPLE_L     (SAMPLE_L),
        .SAMPLE_R     (SAMPLE_R),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .OVR_CLR      (OVR_CLR),
        .OVERRUN      (OVERRUN),
        .UNDERRUN     (UNDERRUN),
        .FRAME_START  (FRAME_START),
        .DAC_BCLK     (DAC_BCLK),
        .DAC_LRCK     (DAC_LRCK),
        .DAC_SDATA    (DAC_SDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a pending pair (or none), the last sent pair, and
    // frame loads at fixed cycle positions after reset release.
    int          m_c;
    bit          m_pend_v;
    logic [31:0] m_pend;
    logic [31:0] m_last;
    bit          m_ovr;
    bit          m_fs;
    bit          m_ur;
    bit          m_load;
    logic [31:0] m_q[$];

    // Serial receiver state
    bit          rx_active;
    int          rx_n;
    logic [31:0] rx_acc;
    logic [31:0] last_rx;
    logic        prev_bclk;

    typedef struct {
        bit          send_a;
        logic [31:0] a;
        bit          send_b;
        logic [31:0] b;
        bit          clr;
        bit          send_c;
        logic [31:0] c;
        logic [31:0] exp_frame;
        bit          exp_ovr;
        bit          exp_ur;
    } row_t;

    row_t rows[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c = 0; m_pend_v = 0; m_pend = '0; m_last = '0; m_ovr = 0;
        m_fs = 0; m_ur = 0; m_load = 0;
        m_q.delete();
        rx_active = 0; rx_n = 0; rx_acc = '0; prev_bclk = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] pair, input bit clr);
        logic [31:0] fr;
        bit set_ovr;
        m_c++;
        m_load = (m_c >= 2 * BD) && ((m_c - 2 * BD) % FRAME == 0);
        m_fs = m_load;
        m_ur = 0;
        if (m_load) begin
            if (m_pend_v) fr = m_pend;
            else begin fr = m_last; m_ur = 1; end
            m_last = fr;
            m_pend_v = 0;
            m_q.delete();
            m_q.push_back(fr);
        end
        set_ovr = v && m_pend_v;
        if (v) begin m_pend = pair; m_pend_v = 1; end
        if (set_ovr) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic check_outputs();
        chk("frame_start", FRAME_START, m_fs);
        chk("underrun", UNDERRUN, m_ur);
        chk("sample_ready", SAMPLE_READY, !m_pend_v);
        chk("overrun", OVERRUN, m_ovr);
        chk("bclk", DAC_BCLK, (m_c / BD) % 2);
        if (m_load) begin
            rx_active = 1; rx_n = 0;
        end else if (rx_active && DAC_BCLK && !prev_bclk) begin
            chk("lrck", DAC_LRCK, (rx_n >= 16));
            rx_acc = {rx_acc[30:0], DAC_SDATA};
            rx_n++;
            if (rx_n == 32) begin
                if (m_q.size() == 0) chk("frame_vs_model", rx_acc, 32'hxxxx_xxxx);
                else chk("frame_vs_model", rx_acc, m_q.pop_front());
                last_rx = rx_acc;
                rx_active = 0; rx_n = 0;
            end
        end
        prev_bclk = DAC_BCLK;
    endtask

    // Called at a negedge; applies inputs across one posedge, checks at the next negedge.
    task automatic step(input bit v, input logic [31:0] pair, input bit clr);
        SAMPLE_VALID = v; SAMPLE_L = pair[31:16]; SAMPLE_R = pair[15:0]; OVR_CLR = clr;
        @(posedge CLK);
        model_edge(v, pair, clr);
        @(negedge CLK);
        SAMPLE_VALID = 1'b0; OVR_CLR = 1'b0;
        check_outputs();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bclk"}, DAC_BCLK, 1'b0);
        chk({tag, "_lrck"}, DAC_LRCK, 1'b0);
        chk({tag, "_sdata"}, DAC_SDATA, 1'b0);
        chk({tag, "_underrun"}, UNDERRUN, 1'b0);
        chk({tag, "_frame_start"}, FRAME_START, 1'b0);
        chk({tag, "_overrun"}, OVERRUN, 1'b0);
        chk({tag, "_ready"}, SAMPLE_READY, 1'b1);
    endtask

    // Called at a negedge with RESET already asserted or about to be.
    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        repeat (10) begin
            @(negedge CLK);
            chk_reset_vals("reset");
        end
        RESET = 1'b0;
    endtask

    initial begin
        bit          ur_seen;
        bit          v;
        bit          clr;
        logic [31:0] p;

        RESET = 1'b1; SAMPLE_VALID = 1'b0; OVR_CLR = 1'b0;
        SAMPLE_L = '0; SAMPLE_R = '0;
        last_rx = '0;

        //          a?  a             b?  b             clr c?  c             frame         ovr ur
        rows[0] = '{1, 32'h1111_2222, 1, 32'h3333_4444, 0, 0, 32'h0,          32'h8001_7FFE, 1, 0};
        rows[1] = '{1, 32'h1234_5678, 0, 32'h0,          1, 0, 32'h0,          32'h3333_4444, 0, 0};
        rows[2] = '{0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          32'h1234_5678, 0, 1};
        rows[3] = '{1, 32'hAAAA_5555, 0, 32'h0,          0, 1, 32'h0F0F_F0F0, 32'h1234_5678, 0, 0};
        rows[4] = '{0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          32'hAAAA_5555, 0, 0};
        rows[5] = '{0, 32'h0,          0, 32'h0,          0, 1, 32'hCAFE_BEEF, 32'h0F0F_F0F0, 0, 1};
        rows[6] = '{0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          32'h0F0F_F0F0, 0, 0};
        rows[7] = '{0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          32'hCAFE_BEEF, 0, 1};

        @(negedge CLK);
        do_reset();

        // Basic frame: pair captured before the first load at cycle 4
        step(1, 32'h8001_7FFE, 0);
        chk("ready_after_valid", SAMPLE_READY, 1'b0);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("no_fs_c3", FRAME_START, 1'b0);
        step(0, '0, 0);
        chk("first_fs_c4", FRAME_START, 1'b1);
        chk("first_load_no_underrun", UNDERRUN, 1'b0);

        // Directed frames, each row ends on a frame load
        for (int i = 0; i < 8; i++) begin
            last_rx = '0;
            ur_seen = 0;
            for (int k = 1; k <= FRAME; k++) begin
                v = 0; p = '0; clr = 0;
                if (rows[i].send_a && k == 10)    begin v = 1; p = rows[i].a; end
                if (rows[i].send_b && k == 60)    begin v = 1; p = rows[i].b; end
                if (rows[i].send_c && k == FRAME) begin v = 1; p = rows[i].c; end
                if (rows[i].clr && k == 100) clr = 1;
                step(v, p, clr);
                if (UNDERRUN) ur_seen = 1;
            end
            chk($sformatf("row%0d_frame", i), last_rx, rows[i].exp_frame);
            chk($sformatf("row%0d_overrun", i), OVERRUN, rows[i].exp_ovr);
            chk($sformatf("row%0d_underrun", i), ur_seen, rows[i].exp_ur);
        end

        // Random traffic against the model
        for (int n = 0; n < 20 * FRAME; n++) begin
            v   = ($urandom_range(0, 79) == 0);
            clr = ($urandom_range(0, 149) == 0);
            p   = $urandom();
            step(v, p, clr);
        end

        // Mid-frame asynchronous reset at bit 10 of an all-ones frame
        step(1, 32'hFFFF_FFFF, 0);
        for (int n = 0; n < 2 * FRAME; n++) begin
            step(0, '0, 0);
            if (m_load) break;
        end
        chk("midrst_at_load", FRAME_START, 1'b1);
        repeat (42) step(0, '0, 0);
        chk("midrst_pre_bclk", DAC_BCLK, 1'b1);
        chk("midrst_pre_sdata", DAC_SDATA, 1'b1);
        #1 RESET = 1'b1;
        #1 chk_reset_vals("async_reset");
        @(negedge CLK);
        do_reset();

        // Restart after reset: first load again at cycle 4, repeating zeros
        repeat (3) step(0, '0, 0);
        chk("restart_no_fs_c3", FRAME_START, 1'b0);
        step(0, '0, 0);
        chk("restart_fs_c4", FRAME_START, 1'b1);
        chk("restart_underrun_c4", UNDERRUN, 1'b1);
        repeat (FRAME) step(0, '0, 0);
        chk("restart_frame", last_rx, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
